// File: rtl/if_id_fetch_queue.sv
// IF/ID instruction queue: first-word-fall-through FIFO of {pc, instr} pairs with flush.
// Define IFQ_BYPASS_EN for a zero-latency empty-queue bypass from fetch to decode.
module if_id_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_plus4,
    output logic [DATA_W-1:0] out_instr,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              stored_valid;
    logic              bypass;
    logic              push, pop, wr_en, rd_en;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;

    always_comb begin
        stored_valid = (count_q != '0);
        in_ready     = (count_q != FULL_C);
`ifdef IFQ_BYPASS_EN
        bypass       = !stored_valid && in_valid && !flush;
`else
        bypass       = 1'b0;
`endif
        out_valid    = stored_valid || bypass;
        head_pc      = bypass ? in_pc    : pc_mem_q[rd_ptr_q];
        head_instr   = bypass ? in_instr : instr_mem_q[rd_ptr_q];
        out_pc       = out_valid ? head_pc : '0;
        out_pc_plus4 = out_valid ? head_pc + ADDR_W'(4) : '0;
        out_instr    = out_valid ? head_instr : '0;
        count        = count_q;

        push  = in_valid && in_ready;
        pop   = out_valid && out_ready;
        // A bypassed entry that decode takes immediately never touches storage.
        wr_en = push && !(bypass && out_ready) && !flush;
        rd_en = pop && stored_valid && !flush;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uncleared on reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed plus random bench for if_id_fetch_queue against a queue-based reference model.
module tb_if_id_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [31:0] pc_m  [$];
    logic [31:0] ins_m [$];

    if_id_fetch_queue #(.DEPTH(4), .PTR_W(2), .DATA_W(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare every output against the model, then advance both.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic r);
        int          n;
        logic        byp, ev, acc, popd;
        logic [31:0] epc, eins;
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl; rst = r;
        #1;
        n = pc_m.size();
`ifdef IFQ_BYPASS_EN
        byp = (n == 0) && v && !fl;
`else
        byp = 1'b0;
`endif
        ev   = (n != 0) || byp;
        epc  = (n != 0) ? pc_m[0]  : (byp ? pc  : 32'h0);
        eins = (n != 0) ? ins_m[0] : (byp ? ins : 32'h0);
        chk("out_valid",    {31'b0, out_valid}, {31'b0, ev});
        chk("in_ready",     {31'b0, in_ready},  {31'b0, n != DEPTH});
        chk("count",        {29'b0, count},     n);
        chk("out_pc",       out_pc,             epc);
        chk("out_pc_plus4", out_pc_plus4,       ev ? epc + 32'd4 : 32'h0);
        chk("out_instr",    out_instr,          eins);
        acc  = v && (n != DEPTH);
        popd = ev && ordy;
        @(posedge clk);
        if (r || fl) begin
            pc_m.delete();
            ins_m.delete();
        end else begin
            if (popd && n != 0) begin
                void'(pc_m.pop_front());
                void'(ins_m.pop_front());
            end
            if (acc && !(byp && ordy)) begin
                pc_m.push_back(pc);
                ins_m.push_back(ins);
            end
        end
        $display("t=%0t v=%0b pc=%h rdy=%0b fl=%0b rst=%0b acc=%0b pop=%0b head=%h cnt=%0d",
                 $time, v, pc, ordy, fl, r, acc && !r && !fl, popd && !r && !fl, epc, n);
        #1;
    endtask

    task automatic idle_check(input string tag, input logic [31:0] pc, input int cnt);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; rst = 1'b0;
        #1;
        chk({tag, "_pc"},    out_pc, pc);
        chk({tag, "_count"}, {29'b0, count}, cnt);
    endtask

    initial begin
        in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0; flush = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;

        // Reset then idle
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Two pushes, head held, then one pop
        step(1, 32'h3000, 32'h3C010001, 0, 0, 0);
        step(1, 32'h3004, 32'h34210002, 0, 0, 0);
        idle_check("two_held", 32'h3000, 2);
        chk("two_held_plus4", out_pc_plus4, 32'h3004);
        step(0, 0, 0, 1, 0, 0);
        idle_check("after_pop", 32'h3004, 1);
        step(0, 0, 0, 1, 0, 0);

        // Fill, reject fifth, drain in order
        for (int i = 0; i < 4; i++) step(1, 32'h100 + 4*i, 32'hA0 + i, 0, 0, 0);
        idle_check("full", 32'h100, 4);
        chk("full_in_ready", {31'b0, in_ready}, 32'h0);
        step(1, 32'h200, 32'hBB, 0, 0, 0);
        step(1, 32'h204, 32'hBC, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) step(1, 32'h500 + 16*k + 4*i, 32'hC0 + i, 0, 0, 0);
            for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        end

        // Count 2 with simultaneous push/pop across the write-pointer wrap
        step(1, 32'h600, 32'hD0, 0, 0, 0);
        step(1, 32'h604, 32'hD1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 32'h608 + 4*i, 32'hD2 + i, 1, 0, 0);
        idle_check("pp_hold", 32'h610, 2);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Flush at count 3 with push and pop requested
        for (int i = 0; i < 3; i++) step(1, 32'h700 + 4*i, 32'hE0 + i, 0, 0, 0);
        step(1, 32'h70C, 32'hE3, 1, 1, 0);
        idle_check("flushed", 32'h0, 0);
        step(1, 32'h4000, 32'h00000013, 0, 0, 0);
        idle_check("post_flush", 32'h4000, 1);
        step(0, 0, 0, 1, 0, 0);

        // Reset mid-operation, then empty-queue push with decode ready
        for (int i = 0; i < 3; i++) step(1, 32'h800 + 4*i, 32'hF0 + i, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h3010, 32'h20420003, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
        end
        step(0, 32'hFFFFFFFC, 0, 0, 0, 0);
        step(1, 32'hFFFFFFFC, 32'h1234, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Instruction queue between the fetch unit (PC/IM) and the decode stage.
- Buffers {PC, instruction} pairs so the fetch stage keeps running while decode stalls.
- Discards all buffered entries on a branch/jump redirect.
- First-word-fall-through FIFO with valid/ready handshakes on both sides.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
PTR_W, 2, pointer width; equals log2(DEPTH)
DATA_W, 32, instruction word width
ADDR_W, 32, PC width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  fetch presents a valid {in_pc, in_instr}
in_ready  output  1  queue can accept an entry this cycle
in_pc  input  ADDR_W  byte address of the fetched instruction
in_instr  input  DATA_W  fetched instruction word
flush  input  1  redirect taken; discard all contents
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_pc  output  ADDR_W  head PC
out_pc_plus4  output  ADDR_W  head PC + 4, modulo 2^ADDR_W
out_instr  output  DATA_W  head instruction; 0x00000000 (NOP) when out_valid=0
count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH-entry register array for pc and instr. Read pointer, write pointer, PTR_W bits each, wrap naturally modulo DEPTH. Occupancy counter is PTR_W+1 bits.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH).
  - No push-through-when-full: a full queue with a same-cycle pop still holds in_ready=0.
  - in_ready does not depend on out_ready. This avoids a combinational path between the two handshakes.
- out_valid = (count != 0). out_pc and out_instr come straight from the register at the read pointer (no output register).
- When out_valid=0:
  - out_instr is forced to 0x00000000.
  - out_pc and out_pc_plus4 are forced to 0.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Flush has highest priority after reset.
  - Any same-cycle push or pop is discarded.
  - Next cycle: count=0, both pointers equal 0, out_valid=0.
  - in_ready is still driven as !full during the flush cycle, but the entry is dropped. Fetch has already been redirected, so the entry is stale.
- Reset (rst=1 at a clock edge):
  - Pointers 0, count 0, out_valid 0, out_instr 0, out_pc 0, out_pc_plus4 0, in_ready 1.
  - Storage contents need not be cleared.
  - Reset mid-operation drops all entries identically to flush.
- Handshake stability: once out_valid=1, the head stays valid and unchanged until popped or flushed.
- count never exceeds DEPTH and never underflows. A pop with count=0 is impossible because out_valid=0.

Optional Feature:
IFQ_BYPASS_EN:
- Defined: zero-latency bypass when empty.
  - With count=0 and in_valid=1 (and flush=0): out_valid=1, and out_pc/out_instr/out_pc_plus4 show the input in the same cycle.
  - If out_ready=1 in that cycle, the entry is consumed and not written; count stays 0.
  - If out_ready=0, the entry is stored normally, provided in_ready=1 (always true when empty).
  - During flush, the bypass is suppressed: out_valid=0.
- Undefined: no combinational in-to-out path; one-cycle latency as above.

Test Plan:
- Reset, then idle -> out_valid=0, out_instr=0x00000000, count=0, in_ready=1.
- Push PC 0x00003000/0x3C010001 then 0x00003004/0x34210002, out_ready=0 -> count=2; head stays 0x00003000, out_pc_plus4=0x00003004. Assert out_ready one cycle -> head becomes 0x00003004, count=1.
- Push 4 entries, out_ready=0 -> count=4, in_ready=0. Drive a 5th with in_valid=1 -> not accepted. Pop all 4 -> PCs emerge in order. Pointer wrap verified by 3 more push/pop rounds.
- Count=2, simultaneous push and pop -> count stays 2; order preserved across the wrap boundary (write pointer 3->0).
- Count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. A following push of 0x00004000 appears at the head one cycle later (or the same cycle with IFQ_BYPASS_EN).
- rst asserted with count=3 -> next cycle count=0, out_valid=0, in_ready=1. With IFQ_BYPASS_EN, empty queue, in_valid=1, out_ready=1, in_pc=0x00003010 -> same-cycle out_valid=1, out_pc=0x00003010, count stays 0.
